// File: rtl/pc_sequencer_pkg.sv
// cadd_ctrl_pkg: shared definitions for the Simple CADD control sequencer.
//   - state_t    : controller FSM states
//   - OP_*       : opcode encodings held in ir[15:12]
//   - IR_*       : instruction-register field boundaries
//   - is_alu_op / is_illegal_op : opcode class helpers
package cadd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_ALU = 3'd4,
        S_UPDATE   = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned IR_OP_MSB  = 15;
    localparam int unsigned IR_OP_LSB  = 12;
    localparam int unsigned IR_TGT_MSB = 7;
    localparam int unsigned IR_TGT_LSB = 0;

    // 0x1..0x7 are ALU operations
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

    // 0xB..0xE are unassigned and execute as NOP
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bus between the sequencer and the PC register,
// instruction memory and ALU.
//   master (sequencer): drives imem_req, alu_op, alu_start, pc_en,
//                       pc_branch, pc_target; receives imem_rdata,
//                       alu_done, alu_zero
//   slave  (datapath) : the reverse directions
interface pc_sequencer_if;

    logic        imem_req;
    logic [15:0] imem_rdata;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic        alu_zero;
    logic        pc_en;
    logic        pc_branch;
    logic [7:0]  pc_target;

    modport master (
        output imem_req, alu_op, alu_start, pc_en, pc_branch, pc_target,
        input  imem_rdata, alu_done, alu_zero
    );

    modport slave (
        input  imem_req, alu_op, alu_start, pc_en, pc_branch, pc_target,
        output imem_rdata, alu_done, alu_zero
    );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM of the Simple CADD core.
// Each instruction runs FETCH, LOAD, EXEC, [WAIT_ALU], UPDATE.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   run      : level, start/continue execution (sampled in IDLE/UPDATE)
//   bus      : imem request/data, ALU start/done/zero, PC strobes+target
//   ir       : instruction register
//   halted   : HALT executed
//   err      : sticky, [0] illegal opcode, [1] ALU timeout
//   retired  : retired-instruction count, wraps
module pc_sequencer
    import cadd_ctrl_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    pc_sequencer_if.master        bus,
    output logic [15:0]           ir,
    output logic                  halted,
    output logic [1:0]            err,
    output logic [15:0]           retired
);

    localparam int unsigned WD_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ALU_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       retired_q, retired_d;
    logic              halted_q, halted_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic [3:0]        opcode;
    logic              op_alu;
    logic              op_illegal;
    logic              take_branch;
    logic              wdog_expired;

    logic              imem_req_o, alu_start_o, pc_en_o, pc_branch_o;

    assign opcode       = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign op_alu       = is_alu_op(opcode);
    assign op_illegal   = is_illegal_op(opcode);
    assign take_branch  = (opcode == OP_JMP)
                        || ((opcode == OP_BZ)  &&  z_q)
                        || ((opcode == OP_BNZ) && !z_q);
    // WAIT_ALU cycle number (1-based) is wdog_q + 1
    assign wdog_expired = (wdog_q == WD_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    state_d = S_LOAD;
            S_LOAD:     state_d = S_EXEC;
            S_EXEC: begin
                if (op_alu)                 state_d = S_WAIT_ALU;
                else if (opcode == OP_HALT) state_d = S_HALT;
                else                        state_d = S_UPDATE;
            end
            S_WAIT_ALU: if (bus.alu_done || wdog_expired) state_d = S_UPDATE;
            S_UPDATE:   state_d = run ? S_FETCH : S_IDLE;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state and registered IR/Z only
    always_comb begin
        imem_req_o  = 1'b0;
        alu_start_o = 1'b0;
        pc_en_o     = 1'b0;
        pc_branch_o = 1'b0;
        unique case (state_q)
            S_FETCH:  imem_req_o  = 1'b1;
            S_EXEC:   alu_start_o = op_alu;
            S_UPDATE: begin
                pc_en_o     = !take_branch;
                pc_branch_o =  take_branch;
            end
            default: ;
        endcase
    end

    assign bus.imem_req  = imem_req_o;
    assign bus.alu_start = alu_start_o;
    assign bus.pc_en     = pc_en_o;
    assign bus.pc_branch = pc_branch_o;
    assign bus.alu_op    = opcode;
    assign bus.pc_target = ir_q[IR_TGT_MSB:IR_TGT_LSB];

    // datapath registers: IR, Z flag, sticky errors, counters
    always_comb begin
        ir_d      = ir_q;
        z_d       = z_q;
        err_d     = err_q;
        retired_d = retired_q;
        halted_d  = halted_q;
        wdog_d    = wdog_q;
        unique case (state_q)
            S_LOAD: ir_d = bus.imem_rdata;
            S_EXEC: begin
                wdog_d = '0;
                if (op_illegal) err_d[0] = 1'b1;
                if (opcode == OP_HALT) begin
                    halted_d  = 1'b1;
                    retired_d = retired_q + 16'd1;
                end
            end
            S_WAIT_ALU: begin
                // done wins over a timeout landing in the same cycle
                if (bus.alu_done)      z_d      = bus.alu_zero;
                else if (wdog_expired) err_d[1] = 1'b1;
                else                   wdog_d   = wdog_q + 1'b1;
            end
            S_UPDATE: retired_d = retired_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q      <= '0;
            z_q       <= 1'b0;
            err_q     <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            ir_q      <= ir_d;
            z_q       <= z_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            wdog_q    <= wdog_d;
        end
    end

    assign ir      = ir_q;
    assign halted  = halted_q;
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic        halted;
    logic [1:0]  err;
    logic [15:0] retired;

    pc_sequencer_if bus ();

    pc_sequencer #(.ALU_TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus),
        .ir      (ir),
        .halted  (halted),
        .err     (err),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned passes = 0;
    int unsigned total  = 0;

    logic [15:0] instr;
    int unsigned cnt_req, cnt_start, cnt_strobe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clr();
        cnt_req    = 0;
        cnt_start  = 0;
        cnt_strobe = 0;
    endtask

    // Tally the current cycle's strobes, advance one clock, then act as
    // instruction memory (data one cycle after the request) and drop
    // the single-cycle alu_done pulse.
    task automatic cyc();
        logic req_prev;
        req_prev   = bus.imem_req;
        cnt_req    += int'(bus.imem_req);
        cnt_start  += int'(bus.alu_start);
        cnt_strobe += int'(bus.pc_en) + int'(bus.pc_branch);
        @(posedge clk);
        #1;
        bus.alu_done = 1'b0;
        if (req_prev) bus.imem_rdata = instr;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        instr = 16'h0000;
        bus.imem_rdata = 16'h0000;
        bus.alu_done = 1'b0;
        bus.alu_zero = 1'b0;
        clr();
        repeat (3) cyc();
        rst = 1'b0;

        // reset state
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_strobes", 32'({bus.imem_req, bus.alu_start, bus.pc_en, bus.pc_branch}), 32'h0);

        // NOP: fetch in cycle 1, pc_en in cycle 4
        instr = 16'h0000;
        run = 1'b1;
        cyc();                                         // FETCH
        chk("nop_req_c1", 32'(bus.imem_req), 32'h1);
        cyc();                                         // LOAD
        chk("nop_req_c2", 32'(bus.imem_req), 32'h0);
        cyc();                                         // EXEC
        chk("nop_no_en_c3", 32'({bus.pc_en, bus.pc_branch}), 32'h0);
        cyc();                                         // UPDATE
        chk("nop_en_c4", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        cyc();                                         // FETCH
        chk("nop_retired", 32'(retired), 32'h1);
        chk("b2b_fetch", 32'(bus.imem_req), 32'h1);

        // ALU op, done 3 cycles after start with zero=1
        instr = 16'h1000;
        bus.alu_zero = 1'b1;
        clr();
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        chk("alu_start", 32'(bus.alu_start), 32'h1);
        chk("alu_op", 32'(bus.alu_op), 32'h1);
        cyc();                                         // WAIT 1
        chk("alu_op_held", 32'(bus.alu_op), 32'h1);
        cyc();                                         // WAIT 2
        cyc();                                         // WAIT 3
        bus.alu_done = 1'b1;
        cyc();                                         // UPDATE
        chk("alu_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        chk("alu_one_start", 32'(cnt_start), 32'h1);
        chk("alu_no_early_strobe", 32'(cnt_strobe), 32'h0);
        cyc();                                         // FETCH

        // BZ taken (Z=1)
        instr = 16'h9020;
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        chk("bz_no_start", 32'(bus.alu_start), 32'h0);
        cyc();                                         // UPDATE
        chk("bz_branch", 32'({bus.pc_en, bus.pc_branch}), 32'h1);
        chk("bz_target", 32'(bus.pc_target), 32'h20);
        cyc();                                         // FETCH

        // BNZ with Z=1 not taken; stray alu_done outside WAIT_ALU ignored
        instr = 16'hA040;
        cyc();                                         // LOAD
        bus.alu_done = 1'b1;
        bus.alu_zero = 1'b0;
        cyc();                                         // EXEC
        cyc();                                         // UPDATE
        chk("bnz_z1_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        cyc();                                         // FETCH

        // ALU op yielding Z=0, done on first WAIT cycle
        instr = 16'h2000;
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        cyc();                                         // WAIT 1
        bus.alu_done = 1'b1;
        bus.alu_zero = 1'b0;
        cyc();                                         // UPDATE
        chk("alu2_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        cyc();                                         // FETCH

        // BNZ with Z=0 taken
        instr = 16'hA040;
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        cyc();                                         // UPDATE
        chk("bnz_z0_branch", 32'({bus.pc_en, bus.pc_branch}), 32'h1);
        chk("bnz_target", 32'(bus.pc_target), 32'h40);
        cyc();                                         // FETCH
        chk("retired_6", 32'(retired), 32'h6);

        // ALU timeout: 16 WAIT cycles then UPDATE with err[1]
        instr = 16'h3000;
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        cyc();                                         // WAIT 1
        clr();
        repeat (15) cyc();                             // WAIT 16
        chk("to_no_strobe_w16", 32'({bus.pc_en, bus.pc_branch}), 32'h0);
        chk("to_no_strobe_w1_15", 32'(cnt_strobe), 32'h0);
        chk("to_err_pending", 32'(err), 32'h0);
        cyc();                                         // UPDATE
        chk("to_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        chk("to_err", 32'(err), 32'h2);
        cyc();                                         // FETCH

        // illegal opcode, then HALT
        instr = 16'hC000;
        clr();
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        cyc();                                         // UPDATE
        chk("ill_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        chk("ill_err", 32'(err), 32'h3);
        cyc();                                         // FETCH
        instr = 16'hF000;
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        chk("halt_not_yet", 32'(halted), 32'h0);
        cyc();                                         // HALT
        chk("ill_one_strobe", 32'(cnt_strobe), 32'h1);
        chk("halted", 32'(halted), 32'h1);
        chk("halt_retired", 32'(retired), 32'h9);
        clr();
        repeat (20) cyc();
        chk("halt_no_req", 32'(cnt_req), 32'h0);
        chk("halt_no_strobe", 32'(cnt_strobe), 32'h0);
        chk("halt_sticky", 32'(halted), 32'h1);

        // reset clears everything
        run = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_ir", 32'(ir), 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_retired", 32'(retired), 32'h0);
        chk("rst2_halted", 32'(halted), 32'h0);

        // mid-instruction reset aborts without a PC strobe
        run = 1'b1;
        instr = 16'h0000;
        cyc();                                         // FETCH
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        rst = 1'b1;
        clr();
        cyc();                                         // IDLE
        rst = 1'b0;
        run = 1'b0;
        cyc();
        cyc();
        chk("abort_no_strobe", 32'(cnt_strobe), 32'h0);
        chk("abort_retired", 32'(retired), 32'h0);

        // run dropped during WAIT_ALU: finish, then stay idle
        run = 1'b1;
        instr = 16'h4000;
        cyc();                                         // FETCH
        cyc();                                         // LOAD
        cyc();                                         // EXEC
        cyc();                                         // WAIT 1
        run = 1'b0;
        cyc();                                         // WAIT 2
        bus.alu_done = 1'b1;
        cyc();                                         // UPDATE
        chk("rundrop_en", 32'({bus.pc_en, bus.pc_branch}), 32'h2);
        cyc();                                         // IDLE
        clr();
        repeat (5) cyc();
        chk("rundrop_no_fetch", 32'(cnt_req), 32'h0);
        chk("rundrop_retired", 32'(retired), 32'h1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
